// File: rtl/minion_pkg.sv
// minion_pkg: shared constants and types for the minion sprite renderer.
//   SPR_W_DEFAULT / SPR_H_DEFAULT : default sprite dimensions (48 x 52)
//   ROM_DEPTH                     : sprite ROM entries (48*52 = 2496)
//   ADDR_W                        : ROM address width presented to the ROM
//   PALETTE                       : 3-bit index -> 24-bit {R,G,B}; index 0 is transparent
//   state_t                       : damage-flash state machine encoding
package minion_pkg;

  localparam int SPR_W_DEFAULT = 48;
  localparam int SPR_H_DEFAULT = 52;
  localparam int ROM_DEPTH     = 2496;
  localparam int ADDR_W        = 19;

  // Entry 0 is never displayed (transparent); it is kept black for clarity.
  localparam logic [23:0] PALETTE [0:7] = '{
    24'h000000,  // 0 transparent
    24'h1A1A1A,  // 1 outline
    24'hFFD800,  // 2 minion yellow
    24'h3A5FCD,  // 3 overalls blue
    24'hF0F0F0,  // 4 goggle white
    24'h8B4513,  // 5 shoe brown
    24'hA0A0A0,  // 6 goggle rim grey
    24'h202020   // 7 pupil
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    FLASH = 2'd2
  } state_t;

endpackage

// File: rtl/minion_sprite_addr.sv
// minion_sprite_addr: combinational stage-0 bounds check and ROM address.
//   i_draw_x/i_draw_y : current draw coordinate
//   i_live_x/i_live_y : live sprite top-left position
//   i_flip            : horizontal mirror (only with MINION_FLIP_EN defined)
//   o_in_box          : coordinate lies inside the sprite rectangle
//   o_addr            : row*SPR_W + col (meaningful only when o_in_box=1)
// Optional feature macro: MINION_FLIP_EN.
module minion_sprite_addr
  import minion_pkg::*;
#(
  parameter int SPR_W = SPR_W_DEFAULT,
  parameter int SPR_H = SPR_H_DEFAULT
) (
  input  logic [9:0]        i_draw_x,
  input  logic [9:0]        i_draw_y,
  input  logic [9:0]        i_live_x,
  input  logic [9:0]        i_live_y,
`ifdef MINION_FLIP_EN
  input  logic              i_flip,
`endif
  output logic              o_in_box,
  output logic [ADDR_W-1:0] o_addr
);

  logic [10:0] w_x_end;
  logic [10:0] w_y_end;
  logic        w_in_x;
  logic        w_in_y;
  logic [9:0]  w_col_raw;
  logic [9:0]  w_col;
  logic [9:0]  w_row;

  // 11-bit upper bounds so a sprite near the right/bottom edge cannot wrap
  // around and produce hits at small coordinates.
  assign w_x_end = {1'b0, i_live_x} + 11'(SPR_W);
  assign w_y_end = {1'b0, i_live_y} + 11'(SPR_H);

  assign w_in_x   = (i_draw_x >= i_live_x) && ({1'b0, i_draw_x} < w_x_end);
  assign w_in_y   = (i_draw_y >= i_live_y) && ({1'b0, i_draw_y} < w_y_end);
  assign o_in_box = w_in_x && w_in_y;

  assign w_col_raw = i_draw_x - i_live_x;
  assign w_row     = i_draw_y - i_live_y;

`ifdef MINION_FLIP_EN
  assign w_col = i_flip ? (10'(SPR_W - 1) - w_col_raw) : w_col_raw;
`else
  assign w_col = w_col_raw;
`endif

  assign o_addr = ADDR_W'(w_row) * ADDR_W'(SPR_W) + ADDR_W'(w_col);

endmodule

// File: rtl/minion_sprite_renderer.sv
// minion_sprite_renderer: pixel pipeline between the sprite ROM and the compositor.
//   Clk, Reset_n            : pixel clock, asynchronous active-low reset
//   draw_x/draw_y/pix_valid : current draw coordinate and active-area flag
//   frame_start             : vertical-blank pulse; commits shadow position, ticks frame counters
//   pos_x/pos_y/pos_wr      : requested sprite position, written to the shadow registers
//   enable, damage          : sprite visibility and damage-flash trigger
//   flip                    : horizontal mirror (only with MINION_FLIP_EN defined)
//   read_address, rom_index : ROM address out (1 clk after coordinate), index back same cycle
//   out_rgb/out_hit/out_valid : palette colour, opaque flag, valid (2 clks after coordinate)
//   flashing                : FSM is in FLASH
// Optional feature macro: MINION_FLIP_EN.
module minion_sprite_renderer
  import minion_pkg::*;
#(
  parameter int SPR_W        = SPR_W_DEFAULT,
  parameter int SPR_H        = SPR_H_DEFAULT,
  parameter int FLASH_FRAMES = 30
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic              pix_valid,
  input  logic              frame_start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              pos_wr,
  input  logic              enable,
  input  logic              damage,
`ifdef MINION_FLIP_EN
  input  logic              flip,
`endif
  output logic [ADDR_W-1:0] read_address,
  input  logic [2:0]        rom_index,
  output logic [23:0]       out_rgb,
  output logic              out_hit,
  output logic              out_valid,
  output logic              flashing
);

  localparam int CNT_W = $clog2(FLASH_FRAMES + 1);

  logic [9:0]        r_shadow_x;
  logic [9:0]        r_shadow_y;
  logic [9:0]        r_live_x;
  logic [9:0]        r_live_y;
  logic [2:0]        r_frame_cnt;

  logic              w_in_box;
  logic [ADDR_W-1:0] w_addr;

  logic [ADDR_W-1:0] r_addr_p0;
  logic              r_hit_p0;
  logic              r_vld_p0;
  logic [2:0]        r_idx_p1;
  logic              r_hit_p1;
  logic              r_vld_p1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_flash_cnt;
  logic [CNT_W-1:0]  w_flash_cnt_nxt;

  // Shadow/live position. A write coinciding with frame_start bypasses the
  // shadow so the new position is live for the very next frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_shadow_x  <= '0;
      r_shadow_y  <= '0;
      r_live_x    <= '0;
      r_live_y    <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (pos_wr) begin
        r_shadow_x <= pos_x;
        r_shadow_y <= pos_y;
      end
      if (frame_start) begin
        r_live_x    <= pos_wr ? pos_x : r_shadow_x;
        r_live_y    <= pos_wr ? pos_y : r_shadow_y;
        r_frame_cnt <= r_frame_cnt + 3'd1;
      end
    end
  end

  minion_sprite_addr #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H)
  ) u_addr (
    .i_draw_x (draw_x),
    .i_draw_y (draw_y),
    .i_live_x (r_live_x),
    .i_live_y (r_live_y),
`ifdef MINION_FLIP_EN
    .i_flip   (flip),
`endif
    .o_in_box (w_in_box),
    .o_addr   (w_addr)
  );

  // ---- stage 0: address and qualifiers registered ----
  // Out-of-box coordinates present address 0 so the ROM never sees an
  // address beyond the sprite.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_addr_p0 <= '0;
      r_hit_p0  <= 1'b0;
      r_vld_p0  <= 1'b0;
    end else begin
      r_addr_p0 <= w_in_box ? w_addr : '0;
      r_hit_p0  <= w_in_box && pix_valid && enable;
      r_vld_p0  <= pix_valid;
    end
  end

  assign read_address = r_addr_p0;

  // ---- stage 1: ROM index registered with qualifiers ----
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_idx_p1 <= '0;
      r_hit_p1 <= 1'b0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_idx_p1 <= rom_index;
      r_hit_p1 <= r_hit_p0;
      r_vld_p1 <= r_vld_p0;
    end
  end

  // ---- stage 2: palette map and flash override ----
  always_comb begin
    out_rgb = '0;
    out_hit = 1'b0;
    if (r_hit_p1 && (r_idx_p1 != 3'd0)) begin
      out_hit = 1'b1;
      out_rgb = ((r_state == FLASH) && r_frame_cnt[2]) ? 24'hFFFFFF : PALETTE[r_idx_p1];
    end
  end

  assign out_valid = r_vld_p1;
  assign flashing  = (r_state == FLASH);

  // Damage-flash FSM: state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= IDLE;
      r_flash_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flash_cnt <= w_flash_cnt_nxt;
    end
  end

  // Damage-flash FSM: next state. Disable overrides everything; damage
  // takes priority over a coincident frame_start while flashing.
  always_comb begin
    w_state_nxt     = r_state;
    w_flash_cnt_nxt = r_flash_cnt;
    if (!enable) begin
      w_state_nxt     = IDLE;
      w_flash_cnt_nxt = '0;
    end else begin
      unique case (r_state)
        IDLE: w_state_nxt = SHOW;
        SHOW: begin
          if (damage) begin
            w_state_nxt     = FLASH;
            w_flash_cnt_nxt = CNT_W'(FLASH_FRAMES);
          end
        end
        FLASH: begin
          if (damage) begin
            w_flash_cnt_nxt = CNT_W'(FLASH_FRAMES);
          end else if (frame_start) begin
            if (r_flash_cnt <= CNT_W'(1)) begin
              w_state_nxt     = SHOW;
              w_flash_cnt_nxt = '0;
            end else begin
              w_flash_cnt_nxt = r_flash_cnt - CNT_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt     = IDLE;
          w_flash_cnt_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minion_sprite_renderer.sv
// Directed testbench for minion_sprite_renderer. The ROM is modelled as
// rom_index = read_address[2:0], so address 154 returns index 2 and
// address 2495 returns index 7. Honours MINION_FLIP_EN.
module tb_minion_sprite_renderer;

  localparam logic [23:0] PAL2  = 24'hFFD800;
  localparam logic [23:0] PAL7  = 24'h202020;
  localparam logic [23:0] WHITE = 24'hFFFFFF;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [9:0]  draw_x = '0, draw_y = '0, pos_x = '0, pos_y = '0;
  logic        pix_valid = 0, frame_start = 0, pos_wr = 0, enable = 0, damage = 0;
`ifdef MINION_FLIP_EN
  logic        flip = 0;
`endif
  logic [18:0] read_address;
  logic [2:0]  rom_index;
  logic [23:0] out_rgb;
  logic        out_hit, out_valid, flashing;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [2:0]  fcnt = '0;

  always #5 Clk = ~Clk;

  assign rom_index = read_address[2:0];

  minion_sprite_renderer dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .draw_x       (draw_x),
    .draw_y       (draw_y),
    .pix_valid    (pix_valid),
    .frame_start  (frame_start),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .pos_wr       (pos_wr),
    .enable       (enable),
    .damage       (damage),
`ifdef MINION_FLIP_EN
    .flip         (flip),
`endif
    .read_address (read_address),
    .rom_index    (rom_index),
    .out_rgb      (out_rgb),
    .out_hit      (out_hit),
    .out_valid    (out_valid),
    .flashing     (flashing)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic frame(input logic wr, input logic [9:0] px, input logic [9:0] py);
    frame_start = 1'b1;
    pos_wr = wr; pos_x = px; pos_y = py;
    tick();
    frame_start = 1'b0;
    pos_wr = 1'b0;
    fcnt = fcnt + 3'd1;
  endtask

  task automatic pulse_damage();
    damage = 1'b1;
    tick();
    damage = 1'b0;
  endtask

  task automatic pixel(input logic [9:0] x, input logic [9:0] y,
                       output logic [18:0] addr, output logic hit,
                       output logic [23:0] rgb, output logic vld);
    draw_x = x; draw_y = y; pix_valid = 1'b1;
    tick();
    addr = read_address;
    pix_valid = 1'b0;
    tick();
    hit = out_hit; rgb = out_rgb; vld = out_valid;
  endtask

  task automatic setup();
    enable = 1'b1;
    frame(1'b1, 10'd100, 10'd200);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    tick(); tick();
    n_tests++; if (read_address !== 19'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", read_address); end
    n_tests++; if (out_rgb !== 24'd0) begin n_fail++; $display("FAIL reset_rgb got %h want 0", out_rgb); end
    n_tests++; if (out_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit got %b want 0", out_hit); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_tests++; if (flashing !== 1'b0) begin n_fail++; $display("FAIL reset_flashing got %b want 0", flashing); end
    Reset_n = 1'b1;
    fcnt = '0;
    tick();
  endtask

  task automatic test_basic();
    logic [18:0] a; logic h, v; logic [23:0] c;
    pixel(10'd110, 10'd203, a, h, c, v);
    n_tests++; if (a !== 19'd154) begin n_fail++; $display("FAIL basic_addr got %0d want 154", a); end
    n_tests++; if (h !== 1'b1) begin n_fail++; $display("FAIL basic_hit got %b want 1", h); end
    n_tests++; if (c !== PAL2) begin n_fail++; $display("FAIL basic_rgb got %h want %h", c, PAL2); end
    n_tests++; if (v !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", v); end
  endtask

  task automatic test_bounds();
    logic [18:0] a; logic h, v; logic [23:0] c;
    pixel(10'd99, 10'd200, a, h, c, v);
    n_tests++; if (h !== 1'b0 || c !== 24'd0) begin n_fail++; $display("FAIL left_edge got hit=%b rgb=%h want 0/0", h, c); end
    pixel(10'd148, 10'd200, a, h, c, v);
    n_tests++; if (h !== 1'b0 || c !== 24'd0) begin n_fail++; $display("FAIL right_edge got hit=%b rgb=%h want 0/0", h, c); end
    n_tests++; if (a !== 19'd0) begin n_fail++; $display("FAIL out_box_addr got %0d want 0", a); end
    pixel(10'd147, 10'd251, a, h, c, v);
    n_tests++; if (a !== 19'd2495) begin n_fail++; $display("FAIL max_addr got %0d want 2495", a); end
    n_tests++; if (h !== 1'b1 || c !== PAL7) begin n_fail++; $display("FAIL max_pix got hit=%b rgb=%h want 1/%h", h, c, PAL7); end
    pixel(10'd100, 10'd252, a, h, c, v);
    n_tests++; if (h !== 1'b0) begin n_fail++; $display("FAIL bottom_edge got hit=%b want 0", h); end
    pixel(10'd100, 10'd200, a, h, c, v);
    n_tests++; if (a !== 19'd0 || h !== 1'b0 || v !== 1'b1) begin n_fail++; $display("FAIL transparent got addr=%0d hit=%b vld=%b want 0/0/1", a, h, v); end
  endtask

  task automatic test_shadow();
    logic [18:0] a; logic h, v; logic [23:0] c;
    pos_x = 10'd300; pos_y = 10'd300; pos_wr = 1'b1;
    tick();
    pos_wr = 1'b0;
    pixel(10'd110, 10'd203, a, h, c, v);
    n_tests++; if (h !== 1'b1) begin n_fail++; $display("FAIL shadow_old_pos got hit=%b want 1", h); end
    pixel(10'd310, 10'd303, a, h, c, v);
    n_tests++; if (h !== 1'b0) begin n_fail++; $display("FAIL shadow_early got hit=%b want 0", h); end
    frame(1'b0, 10'd0, 10'd0);
    pixel(10'd310, 10'd303, a, h, c, v);
    n_tests++; if (a !== 19'd154 || h !== 1'b1) begin n_fail++; $display("FAIL shadow_new_pos got addr=%0d hit=%b want 154/1", a, h); end
    pixel(10'd110, 10'd203, a, h, c, v);
    n_tests++; if (h !== 1'b0) begin n_fail++; $display("FAIL shadow_old_gone got hit=%b want 0", h); end
    frame(1'b1, 10'd100, 10'd200);
    pixel(10'd110, 10'd203, a, h, c, v);
    n_tests++; if (a !== 19'd154 || h !== 1'b1) begin n_fail++; $display("FAIL wr_with_frame got addr=%0d hit=%b want 154/1", a, h); end
  endtask

  task automatic test_wrap();
    logic [18:0] a; logic h, v; logic [23:0] c;
    frame(1'b1, 10'd620, 10'd0);
    pixel(10'd5, 10'd10, a, h, c, v);
    n_tests++; if (h !== 1'b0 || a !== 19'd0) begin n_fail++; $display("FAIL wrap got addr=%0d hit=%b want 0/0", a, h); end
    pixel(10'd630, 10'd10, a, h, c, v);
    n_tests++; if (a !== 19'd490 || h !== 1'b1) begin n_fail++; $display("FAIL right_sprite got addr=%0d hit=%b want 490/1", a, h); end
    pixel(10'd619, 10'd10, a, h, c, v);
    n_tests++; if (h !== 1'b0) begin n_fail++; $display("FAIL right_sprite_left got hit=%b want 0", h); end
    frame(1'b1, 10'd100, 10'd200);
  endtask

  task automatic test_flash();
    logic [18:0] a; logic h, v; logic [23:0] c; logic [23:0] exp_c;
    pulse_damage();
    n_tests++; if (flashing !== 1'b1) begin n_fail++; $display("FAIL flash_start got %b want 1", flashing); end
    for (int i = 1; i <= 30; i++) begin
      frame(1'b0, 10'd0, 10'd0);
      if (i == 2 || i == 6) begin
        exp_c = fcnt[2] ? WHITE : PAL2;
        pixel(10'd110, 10'd203, a, h, c, v);
        n_tests++; if (c !== exp_c || h !== 1'b1) begin n_fail++; $display("FAIL flash_rgb frame %0d got %h want %h", i, c, exp_c); end
        pixel(10'd100, 10'd200, a, h, c, v);
        n_tests++; if (c !== 24'd0 || h !== 1'b0) begin n_fail++; $display("FAIL flash_transp frame %0d got %h want 0", i, c); end
      end
      if (i == 29) begin
        n_tests++; if (flashing !== 1'b1) begin n_fail++; $display("FAIL flash_29 got %b want 1", flashing); end
      end
      if (i == 30) begin
        n_tests++; if (flashing !== 1'b0) begin n_fail++; $display("FAIL flash_30 got %b want 0", flashing); end
      end
    end
    pulse_damage();
    for (int i = 1; i <= 45; i++) begin
      frame(1'b0, 10'd0, 10'd0);
      if (i == 15) pulse_damage();
      if (i == 30 || i == 44) begin
        n_tests++; if (flashing !== 1'b1) begin n_fail++; $display("FAIL flash_ext frame %0d got %b want 1", i, flashing); end
      end
      if (i == 45) begin
        n_tests++; if (flashing !== 1'b0) begin n_fail++; $display("FAIL flash_ext_end got %b want 0", flashing); end
      end
    end
  endtask

  task automatic test_disable();
    logic [18:0] a; logic h, v; logic [23:0] c;
    pulse_damage();
    n_tests++; if (flashing !== 1'b1) begin n_fail++; $display("FAIL dis_pre got %b want 1", flashing); end
    enable = 1'b0;
    tick();
    n_tests++; if (flashing !== 1'b0) begin n_fail++; $display("FAIL dis_idle got %b want 0", flashing); end
    pixel(10'd110, 10'd203, a, h, c, v);
    n_tests++; if (h !== 1'b0 || c !== 24'd0 || v !== 1'b1) begin n_fail++; $display("FAIL dis_pix got hit=%b rgb=%h vld=%b want 0/0/1", h, c, v); end
    enable = 1'b1; damage = 1'b1;
    tick();
    damage = 1'b0;
    tick();
    n_tests++; if (flashing !== 1'b0) begin n_fail++; $display("FAIL idle_damage got %b want 0", flashing); end
    pulse_damage();
    n_tests++; if (flashing !== 1'b1) begin n_fail++; $display("FAIL show_damage got %b want 1", flashing); end
    enable = 1'b0; tick(); enable = 1'b1; tick();
  endtask

  task automatic test_reset_mid();
    pulse_damage();
    draw_x = 10'd110; draw_y = 10'd203; pix_valid = 1'b1;
    tick(); tick();
    pix_valid = 1'b0;
    n_tests++; if (out_hit !== 1'b1 || read_address !== 19'd154) begin n_fail++; $display("FAIL pre_reset got hit=%b addr=%0d want 1/154", out_hit, read_address); end
    #1 Reset_n = 1'b0;
    #1;
    n_tests++; if (read_address !== 19'd0 || out_rgb !== 24'd0 || out_hit !== 1'b0 || out_valid !== 1'b0 || flashing !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset got addr=%0d rgb=%h hit=%b vld=%b fl=%b want all 0", read_address, out_rgb, out_hit, out_valid, flashing);
    end
    tick();
    Reset_n = 1'b1;
    fcnt = '0;
    tick();
    setup();
  endtask

`ifdef MINION_FLIP_EN
  task automatic test_flip();
    logic [18:0] a; logic h, v; logic [23:0] c;
    flip = 1'b1;
    pixel(10'd110, 10'd203, a, h, c, v);
    flip = 1'b0;
    n_tests++; if (a !== 19'd181) begin n_fail++; $display("FAIL flip_addr got %0d want 181", a); end
  endtask
`endif

  initial begin
    test_reset();
    setup();
    test_basic();
    test_bounds();
    test_shadow();
    test_wrap();
    test_flash();
    test_disable();
    test_reset_mid();
    test_basic();
`ifdef MINION_FLIP_EN
    test_flip();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/minion_sprite_renderer.md
# minion_sprite_renderer

Pixel-pipeline stage directly downstream of the 48×52 minion sprite ROM (2496 entries, 3-bit palette index, combinational read). It converts the current VGA draw coordinate into a ROM address, registers the returned index, maps it through the sprite palette, and presents an RGB value plus an opaque-pixel flag to the frame compositor. It also double-buffers the sprite position per frame and runs a damage-flash state machine.

## Interface
Parameters:
- SPR_W, 48, sprite width in pixels
- SPR_H, 52, sprite height in pixels
- FLASH_FRAMES, 30, frames the damage flash lasts

Ports:
- Clk  in  1  pixel clock
- Reset_n  in  1  asynchronous, active-low reset
- draw_x  in  10  current pixel column, 0..639
- draw_y  in  10  current pixel row, 0..479
- pix_valid  in  1  draw_x/draw_y are inside the active area
- frame_start  in  1  one-cycle pulse at the start of vertical blank
- pos_x  in  10  requested sprite top-left column
- pos_y  in  10  requested sprite top-left row
- pos_wr  in  1  latch pos_x/pos_y into the shadow registers
- enable  in  1  sprite is drawn when 1
- damage  in  1  one-cycle pulse; starts the flash
- flip  in  1  horizontal mirror; present only with MINION_FLIP_EN
- read_address  out  19  sprite ROM address
- rom_index  in  3  palette index returned by the ROM, same cycle
- out_rgb  out  24  {R,G,B}, 8 bits each
- out_hit  out  1  sprite pixel is opaque at this coordinate
- out_valid  out  1  out_rgb/out_hit correspond to a pix_valid input
- flashing  out  1  state is FLASH

## Operation
- Shadow position: pos_wr loads shadow_x/y. On frame_start, the live position loads from the shadow. If pos_wr and frame_start occur together, the new pos_x/y go straight to the live registers.
- Stage 0: in_box = draw_x ≥ live_x and draw_x < live_x+SPR_W, and the same test on y. Comparisons use 11-bit arithmetic, so a sprite at pos_x=620 does not wrap to column 0. col = draw_x−live_x and row = draw_y−live_y. read_address = row*SPR_W + col, zero-extended to 19 bits, and is registered. With the macro enabled and flip=1, col is replaced by SPR_W−1−col. Registered with the address: in_box & pix_valid & enable, and pix_valid.
- Stage 1: rom_index is registered together with the stage-0 qualifiers.
- Stage 2: index 0 is transparent. If qualified and index≠0, out_hit=1 and out_rgb=PALETTE[index]. Otherwise out_hit=0 and out_rgb=0. In FLASH, with frame_cnt[2]=1, opaque pixels output 24'hFFFFFF.
- State machine:
  - IDLE → SHOW when enable=1.
  - SHOW → FLASH on damage; flash_cnt loads FLASH_FRAMES.
  - FLASH decrements flash_cnt on each frame_start and goes to SHOW at 0.
  - damage in FLASH reloads flash_cnt.
  - enable=0 in any state → IDLE and clears flash_cnt.
  - damage in IDLE is ignored.
- frame_cnt is a free-running 3-bit counter incremented on frame_start.

## Timing
- Latency: draw_x/draw_y to out_rgb/out_hit/out_valid is 2 clocks. read_address is 1 clock after the coordinate.
- The ROM is combinational; rom_index is sampled in the cycle read_address is presented.
- Position change becomes visible on the first pixel after frame_start, never mid-frame.
- Reset values: read_address=0, out_rgb=0, out_hit=0, out_valid=0, flashing=0, state IDLE, live/shadow position 0, counters 0.
- Reset asserted mid-frame clears the pipeline immediately; the outputs are 0 from the first cycle of reset.
- Maximum address is (SPR_H−1)*SPR_W+SPR_W−1 = 2495; an address is never issued while in_box=0.

## Configuration
- MINION_FLIP_EN defined: the flip port exists and mirrors col as above.
- Undefined: no flip port; col = draw_x−live_x always.

## Structure
- Package minion_pkg contains:
  - SPR_W/SPR_H defaults;
  - the 8-entry 24-bit PALETTE constant;
  - the state enum typedef (IDLE, SHOW, FLASH);
  - the ROM depth constant 2496.
- One sub-module, minion_sprite_addr: stage-0 bounds check and address/flip computation, purely combinational. The top level owns all registers and the FSM.

## Test plan
- Position (100,200), pix_valid=1, draw (110,203) → read_address=154 one cycle later. With rom_index=2, out_hit=1 and out_rgb=PALETTE[2] two cycles after the coordinate.
- Draw (99,200) and (148,200) at the same position → out_hit=0 and out_rgb=0; (147,251) → address 2495.
- pos_wr to (300,300) mid-frame → hits stay at (100,200) until frame_start, then move to (300,300). Simultaneous pos_wr and frame_start → the new position is live immediately.
- Position (620,0), draw (5,10) → out_hit=0, with no wrap-around hit.
- damage, then 30 frame_start pulses → flashing=1 for exactly 30 frames, with white on opaque pixels when frame_cnt[2]=1. A damage at frame 15 extends the flash to frame 45. enable=0 → IDLE, out_hit=0.
- Reset_n low mid-frame → all outputs are 0 on the next edge. With MINION_FLIP_EN and flip=1, draw (110,203) → address 3*48+37=181.
